// File: rtl/lcd_bus_driver_if.sv
// Byte handshake between the LCD page controller and the bus driver.
// The controller offers {rs, data} and the driver answers with ready.
interface lcd_bus_driver_if;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic       cmd_rs_i;
    logic [7:0] cmd_data_i;

    modport master (
        output cmd_valid_i,
        output cmd_rs_i,
        output cmd_data_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i,
        input  cmd_rs_i,
        input  cmd_data_i,
        output cmd_ready_o
    );
endinterface

// File: rtl/lcd_bus_driver.sv
// HD44780 8-bit write-only bus timing stage (setup, E pulse, hold, exec wait).
// Define LCD_POWERON_INIT_EN to build in the power-on init sequence.
module lcd_bus_driver #(
    parameter int SETUP_CYCLES     = 4,
    parameter int PULSE_CYCLES     = 25,
    parameter int HOLD_CYCLES      = 2,
    parameter int EXEC_CYCLES      = 2000,
    parameter int LONG_EXEC_CYCLES = 80000,
    parameter int POWERON_CYCLES   = 2000000
) (
    input  logic             fpga_clk_i,
    input  logic             fpga_reset_i,
    lcd_bus_driver_if.slave  cmd,
    output logic             busy_o,
    output logic             init_done_o,
    output logic [7:0]       lcd_data_o,
    output logic             lcd_rs_o,
    output logic             lcd_rw_o,
    output logic             lcd_enable_o
);

    localparam int M0 = (SETUP_CYCLES > PULSE_CYCLES) ?
                        SETUP_CYCLES : PULSE_CYCLES;
    localparam int M1 = (M0 > HOLD_CYCLES) ? M0 : HOLD_CYCLES;
    localparam int M2 = (M1 > EXEC_CYCLES) ? M1 : EXEC_CYCLES;
    localparam int M3 = (M2 > LONG_EXEC_CYCLES) ?
                        M2 : LONG_EXEC_CYCLES;
`ifdef LCD_POWERON_INIT_EN
    localparam int MAXC = (M3 > POWERON_CYCLES) ?
                          M3 : POWERON_CYCLES;
`else
    localparam int MAXC = M3;
`endif
    localparam int CW = $clog2(MAXC + 1);

`ifdef LCD_POWERON_INIT_EN
    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_LOAD,
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        WAIT
    } state_t;
`endif

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            long_wait;
    logic            accept;

`ifdef LCD_POWERON_INIT_EN
    logic [2:0]      init_idx;
    logic            init_done;

    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = 8'h38;
            3'd1:    b = 8'h38;
            3'd2:    b = 8'h38;
            3'd3:    b = 8'h0C;
            3'd4:    b = 8'h01;
            default: b = 8'h06;
        endcase
        return b;
    endfunction

    assign init_done_o = init_done;
`else
    assign init_done_o = 1'b1;
`endif

    assign cmd.cmd_ready_o = (state == IDLE) && init_done_o;
    assign busy_o          = (state != IDLE);
    assign lcd_rw_o        = 1'b0;
    assign accept          = cmd.cmd_valid_i && cmd.cmd_ready_o;

    // Clear (0x01) and home (0x02/0x03) need the long execution time.
    assign long_wait = !lcd_rs_o &&
                       (lcd_data_o[7:2] == 6'd0) &&
                       (lcd_data_o[1:0] != 2'd0);

    always_ff @(posedge fpga_clk_i or posedge fpga_reset_i) begin
        if (fpga_reset_i) begin
`ifdef LCD_POWERON_INIT_EN
            state     <= PWR_WAIT;
            cnt       <= CW'(POWERON_CYCLES - 1);
            init_idx  <= 3'd0;
            init_done <= 1'b0;
`else
            state     <= IDLE;
            cnt       <= '0;
`endif
            lcd_data_o   <= 8'h00;
            lcd_rs_o     <= 1'b0;
            lcd_enable_o <= 1'b0;
        end else begin
            unique case (state)
`ifdef LCD_POWERON_INIT_EN
                PWR_WAIT: begin
                    if (cnt == '0) begin
                        state <= INIT_LOAD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                INIT_LOAD: begin
                    lcd_rs_o   <= 1'b0;
                    lcd_data_o <= init_byte(init_idx);
                    cnt        <= CW'(SETUP_CYCLES - 1);
                    state      <= SETUP;
                end
`endif
                IDLE: begin
                    if (accept) begin
                        lcd_rs_o   <= cmd.cmd_rs_i;
                        lcd_data_o <= cmd.cmd_data_i;
                        cnt        <= CW'(SETUP_CYCLES - 1);
                        state      <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        lcd_enable_o <= 1'b1;
                        cnt          <= CW'(PULSE_CYCLES - 1);
                        state        <= PULSE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        lcd_enable_o <= 1'b0;
                        cnt          <= CW'(HOLD_CYCLES - 1);
                        state        <= HOLD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= long_wait ?
                                 CW'(LONG_EXEC_CYCLES - 1) :
                                 CW'(EXEC_CYCLES - 1);
                        state <= WAIT;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
`ifdef LCD_POWERON_INIT_EN
                        if (init_done) begin
                            state <= IDLE;
                        end else if (init_idx == 3'd5) begin
                            init_done <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            init_idx <= init_idx + 3'd1;
                            state    <= INIT_LOAD;
                        end
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    lcd_enable_o <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// Scoreboard bench for lcd_bus_driver with shortened timing parameters.
// Bytes are queued when offered and checked on every rising E edge.
module tb_lcd_bus_driver;

    localparam int S  = 2;
    localparam int P  = 4;
    localparam int H  = 1;
    localparam int EX = 10;
    localparam int LG = 50;
    localparam int PW = 100;

`ifdef LCD_POWERON_INIT_EN
    localparam bit INIT_EN = 1'b1;
`else
    localparam bit INIT_EN = 1'b0;
`endif

    localparam logic [7:0] INIT_SEQ [6] =
        '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       busy;
    logic       init_done;
    logic [7:0] lcd_data;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int pulses   = 0;
    int rise_cyc = 0;

    logic [8:0] sb [$];

    lcd_bus_driver_if bus ();

    lcd_bus_driver #(
        .SETUP_CYCLES     (S),
        .PULSE_CYCLES     (P),
        .HOLD_CYCLES      (H),
        .EXEC_CYCLES      (EX),
        .LONG_EXEC_CYCLES (LG),
        .POWERON_CYCLES   (PW)
    ) dut (
        .fpga_clk_i   (clk),
        .fpga_reset_i (rst),
        .cmd          (bus),
        .busy_o       (busy),
        .init_done_o  (init_done),
        .lcd_data_o   (lcd_data),
        .lcd_rs_o     (lcd_rs),
        .lcd_rw_o     (lcd_rw),
        .lcd_enable_o (lcd_en)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bus protocol monitor and scoreboard consumer.
    initial begin
        logic       prev_e;
        logic [8:0] prev_bus;
        logic [8:0] cur;
        logic [8:0] exp;
        int         high_cnt;
        int         stable;
        int         hold_left;
        prev_e    = 1'b0;
        prev_bus  = '0;
        high_cnt  = 0;
        stable    = 0;
        hold_left = 0;
        forever begin
            @(negedge clk);
            cur = {lcd_rs, lcd_data};
            if (rst) begin
                prev_e    = 1'b0;
                prev_bus  = cur;
                high_cnt  = 0;
                stable    = 0;
                hold_left = 0;
            end else begin
                if (cur != prev_bus) begin
                    chk("bus_chg_in_pulse_or_hold",
                        32'(lcd_en || prev_e || hold_left != 0), 0);
                    stable = 0;
                end
                if (lcd_en && !prev_e) begin
                    pulses++;
                    rise_cyc = cyc;
                    chk("setup_ge_s", 32'(stable >= S), 1);
                    chk("rw_zero", 32'(lcd_rw), 0);
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 1, 0);
                    end else begin
                        exp = sb.pop_front();
                        chk("pulse_rs", 32'(lcd_rs), 32'(exp[8]));
                        chk("pulse_data", 32'(lcd_data), 32'(exp[7:0]));
                    end
                    high_cnt = 1;
                end else if (lcd_en) begin
                    high_cnt++;
                end else if (prev_e) begin
                    chk("e_width", high_cnt, P);
                    hold_left = H - 1;
                end else if (hold_left > 0) begin
                    hold_left--;
                end
                stable++;
                prev_e   = lcd_en;
                prev_bus = cur;
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int bound);
        int i;
        for (i = 0; i < bound && !bus.cmd_ready_o; i++) step();
        if (!bus.cmd_ready_o) chk(tag, 0, 1);
    endtask

    task automatic offer(input logic rs, input logic [7:0] d,
                         output int t0);
        wait_ready("offer_ready_timeout", 1000);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_rs_i    = rs;
        bus.cmd_data_i  = d;
        sb.push_back({rs, d});
        step();
        t0 = cyc;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_data_i  = ~d;
        bus.cmd_rs_i    = ~rs;
    endtask

    task automatic send(input logic rs, input logic [7:0] d,
                        input int lat);
        int t0;
        int i;
        offer(rs, d, t0);
        chk("lat_rs", 32'(lcd_rs), 32'(rs));
        chk("lat_data", 32'(lcd_data), 32'(d));
        chk("busy_after_accept", 32'(busy), 1);
        chk("ready_after_accept", 32'(bus.cmd_ready_o), 0);
        for (i = 0; i < 200 && !bus.cmd_ready_o; i++) step();
        chk("ready_latency", cyc + 1 - t0, lat);
        chk("e_rise_offset", rise_cyc + 1 - t0, S + 1);
    endtask

    task automatic init_phase();
        int  low;
        int  p0;
        int  i;
        bit  mis;
        low = 0;
        mis = 1'b0;
        p0  = pulses;
        for (i = 0; i < 6; i++) sb.push_back({1'b0, INIT_SEQ[i]});
        for (i = 0; i < 3000 && !bus.cmd_ready_o; i++) begin
            if (init_done !== bus.cmd_ready_o) mis = 1'b1;
            low++;
            step();
        end
        if (init_done !== bus.cmd_ready_o) mis = 1'b1;
        chk("init_ready_seen", 32'(bus.cmd_ready_o), 1);
        chk("init_low_ge_pw", 32'(low >= PW), 1);
        chk("init_done_with_ready", 32'(mis), 0);
        chk("init_pulses", pulses - p0, 6);
        chk("init_sb_drained", sb.size(), 0);
    endtask

    initial begin
        int t0;
        int acc;
        int p0;
        int i;
        logic [7:0] d;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_rs_i    = 1'b0;
        bus.cmd_data_i  = 8'h00;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_en", 32'(lcd_en), 0);
        chk("rst_data", 32'(lcd_data), 0);
        chk("rst_rs", 32'(lcd_rs), 0);
        chk("rst_rw", 32'(lcd_rw), 0);
        chk("rst_ready", 32'(bus.cmd_ready_o), 32'(!INIT_EN));
        chk("rst_init_done", 32'(init_done), 32'(!INIT_EN));
        chk("rst_busy", 32'(busy), 32'(INIT_EN));
        rst = 1'b0;
        if (INIT_EN) init_phase();

        send(1'b1, 8'h41, 18);
        send(1'b0, 8'h01, 58);
        send(1'b0, 8'h04, 18);
        send(1'b0, 8'h02, 58);
        send(1'b0, 8'h03, 58);
        send(1'b1, 8'h01, 18);
        send(1'b0, 8'h00, 18);
        send(1'b0, 8'hFC, 18);

        // Valid held high with data changing every cycle.
        acc = 0;
        p0  = pulses;
        bus.cmd_valid_i = 1'b1;
        for (i = 0; i < 60; i++) begin
            d = 8'($urandom);
            bus.cmd_rs_i   = 1'b1;
            bus.cmd_data_i = d;
            if (bus.cmd_ready_o) begin
                sb.push_back({1'b1, d});
                acc++;
            end
            step();
        end
        bus.cmd_valid_i = 1'b0;
        wait_ready("held_ready_timeout", 200);
        chk("held_accepts", acc, 4);
        chk("held_pulses", pulses - p0, acc);

        // Reset while E is high.
        offer(1'b1, 8'h5A, t0);
        for (i = 0; i < 20 && !lcd_en; i++) step();
        chk("pre_rst_e_high", 32'(lcd_en), 1);
        step();
        rst = 1'b1;
        #1;
        chk("midrst_en", 32'(lcd_en), 0);
        chk("midrst_data", 32'(lcd_data), 0);
        chk("midrst_rs", 32'(lcd_rs), 0);
        chk("midrst_busy", 32'(busy), 32'(INIT_EN));
        step();
        rst = 1'b0;
        if (INIT_EN) init_phase();
        send(1'b1, 8'h41, 18);

        repeat (5) step();
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

Bus-timing stage directly downstream of the LCD page controller. It takes one byte at a time (command or character) through a valid/ready handshake and drives an HD44780-compatible 8-bit parallel interface with the required setup, enable-pulse, hold and execution-wait timing. The controller never drives LCD pins directly; it only pushes `{rs, data}` bytes here. An optional built-in power-on initialisation sequence brings the display into a known mode before the first byte is accepted.

## Interface
- `SETUP_CYCLES`, 4: cycles that RS/data are stable before E rises; must be ≥1.
- `PULSE_CYCLES`, 25: E high width in cycles; must be ≥1.
- `HOLD_CYCLES`, 2: cycles RS/data are held after E falls; must be ≥1.
- `EXEC_CYCLES`, 2000: post-write wait for normal instructions and data.
- `LONG_EXEC_CYCLES`, 80000: post-write wait for clear/home.
- `POWERON_CYCLES`, 2000000: power-up wait, used only when init is compiled in.
- `fpga_clk_i` in 1: single clock.
- `fpga_reset_i` in 1: asynchronous, active-high reset.
- `cmd_valid_i` in 1: byte offered.
- `cmd_ready_o` out 1: block can accept a byte.
- `cmd_rs_i` in 1: 0 = instruction, 1 = character data.
- `cmd_data_i` in 8: byte value.
- `busy_o` out 1: high whenever the FSM is outside IDLE.
- `init_done_o` out 1: power-on sequence finished.
- `lcd_data_o` out 8: LCD DB7..DB0.
- `lcd_rs_o` out 1: LCD RS.
- `lcd_rw_o` out 1: LCD R/W. Constant 0 (write-only).
- `lcd_enable_o` out 1: LCD E.

## Operation
- **FSM states:** PWR_WAIT, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT. PWR_WAIT and INIT_LOAD exist only when the init feature is compiled in.
- **Handshake:** `cmd_ready_o` = (state==IDLE) && `init_done_o`. A transfer occurs on a rising edge with `cmd_valid_i && cmd_ready_o`. At that edge the block latches `cmd_rs_i` and `cmd_data_i` and moves to SETUP.
- **Write sequence:**
  - IDLE → SETUP: `lcd_rs_o` and `lcd_data_o` take the latched values.
  - SETUP → PULSE: E=1.
  - PULSE → HOLD: E=0, RS/data unchanged.
  - HOLD → WAIT → IDLE.
- **Wait length:** one down-counter, sized by `$clog2` of the largest parameter, loads the cycle count for each timed state. The long wait applies when rs==0 and data ∈ {0x01, 0x02, 0x03} (i.e. data[7:2]==0 and data≠0). Every other byte uses `EXEC_CYCLES`.
- **Output retention:** `lcd_data_o` and `lcd_rs_o` keep the last written value after HOLD until the next SETUP.
- **Input sampling:** `cmd_valid_i` while not ready is ignored. Input changes have no effect outside the accept edge.
- **Reset values:** `cmd_ready_o` = 0 (init compiled in) or 1 (init compiled out); `busy_o` follows state; `init_done_o` = 0 (in) or 1 (out); `lcd_data_o` = 0x00; `lcd_rs_o` = 0; `lcd_enable_o` = 0.
- **Reset mid-operation:** asynchronous. E drops immediately and the in-flight byte is discarded. After release the FSM restarts from PWR_WAIT (init in) or IDLE (init out).

## Timing
- Accept edge at T0 → SETUP occupies cycles T0+1 .. T0+S.
- E is high for cycles T0+S+1 .. T0+S+P.
- HOLD occupies the next H cycles, then WAIT occupies E_x cycles.
- `cmd_ready_o` reasserts in cycle T0+1+S+P+H+E_x. With defaults and a normal byte, that is T0+2032.
- A new byte can be accepted on the first cycle ready is high. There is no back-to-back acceptance without the full wait.
- E is never high during SETUP, HOLD, WAIT or IDLE. RS/data never change while E is high or during HOLD.

## Configuration
- Macro: `LCD_POWERON_INIT_EN`.
- **Defined:**
  - After reset, the block waits `POWERON_CYCLES` in PWR_WAIT.
  - It then writes the instructions 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06, in that order, using the normal write sequence. 0x01 uses the long wait.
  - `init_done_o` rises in the cycle the FSM returns to IDLE after 0x06. External bytes are refused until then.
- **Undefined:** no init states. `init_done_o` is tied to 1, and the FSM comes out of reset in IDLE with `cmd_ready_o` = 1.

## Test plan
All scenarios use bench parameters S=2, P=4, H=1, EXEC=10, LONG=50, POWERON=100.
- **Data write (init out):** accept {rs=1, 0x41} at T0 → RS=1 and data=0x41 from T0+1; E high exactly at T0+3..T0+6; ready returns at T0+18.
- **Clear instruction:** accept {rs=0, 0x01} → ready returns at T0+58. Repeat with {rs=0, 0x04} → ready returns at T0+18.
- **Valid held through busy:** hold valid=1 with changing data while busy → only the byte present on the ready edge appears on `lcd_data_o`; exactly one E pulse per accept.
- **Reset during PULSE:** assert reset mid-E → E=0, data=0x00 and RS=0 in the same cycle. After release, the first accept behaves as in the data-write scenario.
- **Init in (`LCD_POWERON_INIT_EN` defined):** ready=0 for 100 cycles, then exactly six E pulses carrying 0x38, 0x38, 0x38, 0x0C, 0x01, 0x06 with RS=0. `init_done_o` and ready rise together after the final wait.
- **Protocol checker, all runs:** E high width == P; RS/data stable ≥ S cycles before and ≥ H cycles after every pulse; `lcd_rw_o` always 0.
